// File: rtl/contador_cascata.sv
// Cascaded BCD down-counter with clamped preset load, zero flag and end-of-count pulse.
// Optional feature: define CONTADOR_CASCATA_AUTO_RECARGA_EN to reload the preset after reaching zero.
module contador_cascata #(
  parameter int DIGITS  = 2,
  parameter int LOW_MAX = 9,
  parameter int TOP_MAX = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  botao,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  habilita,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  zero,
  output logic                  fim,
  output logic [1:0]            estado
);

  // state    | meaning
  // PARADO   | idle after reset, waiting for a load
  // CONTANDO | counting down on each enabled clock
  // FIM      | count finished (or zero loaded), Q held
  typedef enum logic [1:0] {
    PARADO   = 2'b00,
    CONTANDO = 2'b01,
    FIM      = 2'b10
  } state_t;

  localparam int W = 4 * DIGITS;

  state_t          state, state_nxt;
  logic [W-1:0]    q_nxt;
  logic [W-1:0]    reload, reload_nxt;
  logic [W-1:0]    clamped, decremented;
  logic            fim_nxt;
  logic [3:0]      dig;
  logic [3:0]      pre;
  logic            borrow;

  function automatic logic [3:0] digit_max(input int i);
    return (i == DIGITS - 1) ? 4'(TOP_MAX) : 4'(LOW_MAX);
  endfunction

  // A digit decrements only while every lower digit is zero; a borrowing zero wraps to its max.
  always_comb begin
    clamped     = '0;
    decremented = '0;
    dig         = '0;
    pre         = '0;
    borrow      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig = Q[4*i +: 4];
      pre = preset[4*i +: 4];
      clamped[4*i +: 4] = (pre > digit_max(i)) ? digit_max(i) : pre;
      if (borrow)
        decremented[4*i +: 4] = (dig == 4'd0) ? digit_max(i) : dig - 4'd1;
      else
        decremented[4*i +: 4] = dig;
      borrow = borrow & (dig == 4'd0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= PARADO;
      Q      <= '0;
      reload <= '0;
      fim    <= 1'b0;
    end else begin
      state  <= state_nxt;
      Q      <= q_nxt;
      reload <= reload_nxt;
      fim    <= fim_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    q_nxt      = Q;
    reload_nxt = reload;
    fim_nxt    = 1'b0;
    if (botao) begin
      q_nxt      = clamped;
      reload_nxt = clamped;
      state_nxt  = (clamped != '0) ? CONTANDO : FIM;
    end else if (state == CONTANDO && habilita) begin
`ifdef CONTADOR_CASCATA_AUTO_RECARGA_EN
      // Zero is shown for one enabled clock (with the fim pulse) before the reload.
      if (Q == '0) begin
        q_nxt = reload;
      end else begin
        q_nxt   = decremented;
        fim_nxt = (decremented == '0);
      end
`else
      q_nxt = decremented;
      if (decremented == '0) begin
        fim_nxt   = 1'b1;
        state_nxt = FIM;
      end
`endif
    end
  end

  always_comb begin
    zero   = (Q == '0);
    estado = state;
  end

endmodule

// File: tb/tb_contador_cascata.sv
// Scoreboard bench for contador_cascata: an arithmetic reference model predicts each cycle,
// a monitor on the falling edge compares DUT outputs against the queued predictions.
module tb_contador_cascata;

  localparam int DIGITS  = 2;
  localparam int LOW_MAX = 9;
  localparam int TOP_MAX = 5;
  localparam int BASE    = LOW_MAX + 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       botao;
  logic [7:0] preset;
  logic       habilita;
  logic [7:0] Q;
  logic       zero;
  logic       fim;
  logic [1:0] estado;

  typedef struct {
    logic [7:0] q;
    logic       zero;
    logic       fim;
    logic [1:0] st;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // reference model: count held as a plain integer in mixed radix
  int         m_n;
  int         m_reload;
  logic [1:0] m_st;
  logic       m_fim;

  contador_cascata #(.DIGITS(DIGITS), .LOW_MAX(LOW_MAX), .TOP_MAX(TOP_MAX)) dut (
    .clock(clock), .reset(reset), .botao(botao), .preset(preset),
    .habilita(habilita), .Q(Q), .zero(zero), .fim(fim), .estado(estado)
  );

  always #5 clock = ~clock;

  function automatic int clamp_val(input logic [7:0] p);
    int d0, d1;
    d0 = (int'(p[3:0]) > LOW_MAX) ? LOW_MAX : int'(p[3:0]);
    d1 = (int'(p[7:4]) > TOP_MAX) ? TOP_MAX : int'(p[7:4]);
    return d1 * BASE + d0;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] hi, lo;
    hi = 4'(n / BASE);
    lo = 4'(n % BASE);
    return {hi, lo};
  endfunction

  task automatic model_reset();
    m_n = 0; m_reload = 0; m_st = 2'b00; m_fim = 1'b0;
  endtask

  task automatic model_edge(input logic b, input logic [7:0] p, input logic h);
    m_fim = 1'b0;
    if (b) begin
      m_n      = clamp_val(p);
      m_reload = m_n;
      m_st     = (m_n != 0) ? 2'b01 : 2'b10;
    end else if (m_st == 2'b01 && h) begin
`ifdef CONTADOR_CASCATA_AUTO_RECARGA_EN
      if (m_n == 0) m_n = m_reload;
      else begin
        m_n = m_n - 1;
        if (m_n == 0) m_fim = 1'b1;
      end
`else
      m_n = m_n - 1;
      if (m_n == 0) begin
        m_fim = 1'b1;
        m_st  = 2'b10;
      end
`endif
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.q    = to_bcd(m_n);
    e.zero = (m_n == 0);
    e.fim  = m_fim;
    e.st   = m_st;
    sbq.push_back(e);
  endtask

  // Inputs are applied before the edge; reset (if requested) is pulsed between edges.
  task automatic cycle(input logic b, input logic [7:0] p, input logic h, input logic rst_mid);
    botao = b; preset = p; habilita = h;
    @(posedge clock);
    if (!reset) model_edge(b, p, h);
    #1;
    if (rst_mid) begin
      reset = 1'b1;
      model_reset();
    end
    push_exp();
    if (rst_mid) begin
      @(negedge clock);
      #1 reset = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (Q !== e.q) begin
          failures++;
          $display("FAIL q t=%0t got=%h exp=%h", $time, Q, e.q);
        end
        checks++;
        if (zero !== e.zero) begin
          failures++;
          $display("FAIL zero t=%0t got=%b exp=%b", $time, zero, e.zero);
        end
        checks++;
        if (fim !== e.fim) begin
          failures++;
          $display("FAIL fim t=%0t got=%b exp=%b", $time, fim, e.fim);
        end
        checks++;
        if (estado !== e.st) begin
          failures++;
          $display("FAIL estado t=%0t got=%b exp=%b", $time, estado, e.st);
        end
      end
    end
  end

  initial begin
    logic       b, h, r;
    logic [7:0] p;
    reset = 1'b1; botao = 1'b0; preset = '0; habilita = 1'b0;
    model_reset();
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    reset = 1'b0;
    cycle(0, 8'h00, 1, 0);                       // PARADO ignores habilita

    cycle(1, 8'h12, 1, 0);                       // full countdown to zero
    repeat (14) cycle(0, 8'h00, 1, 0);

    cycle(1, 8'h7A, 0, 0);                       // both digits clamped
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h3F, 1, 0);                       // low digit clamped only

    cycle(1, 8'h31, 0, 0);
    cycle(0, 8'h00, 1, 0);                       // Q=30
    cycle(1, 8'h45, 1, 0);                       // load wins over decrement

    cycle(1, 8'h28, 0, 0);
    cycle(0, 8'h00, 1, 0);                       // Q=27
    cycle(0, 8'h00, 0, 1);                       // async reset between edges
    cycle(0, 8'h00, 1, 0);

    cycle(1, 8'h05, 0, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 1, 0);

    cycle(1, 8'h00, 1, 0);                       // zero load: FIM without pulse
    repeat (3) cycle(0, 8'h00, 1, 0);

    cycle(1, 8'h02, 1, 0);                       // short count / auto reload path
    repeat (6) cycle(0, 8'h00, 1, 0);

    cycle(1, 8'h10, 1, 0);                       // borrow across the digit boundary
    repeat (3) cycle(0, 8'h00, 1, 0);

    for (int k = 0; k < 600; k++) begin
      b = ($urandom_range(0, 24) == 0);
      p = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h15));
      h = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 79) == 0);
      cycle(b, p, h, r);
    end

    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/contador_cascata.md
CONTADOR_CASCATA -- requirements
Module: contador_cascata

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of 4-bit BCD digits in the chain (range 1..8).
REQ-002 SHALL have parameter LOW_MAX, default 9, maximum value of every digit except the most significant (range 1..9).
REQ-003 SHALL have parameter TOP_MAX, default 5, maximum value of the most significant digit (range 1..9).
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port botao  input  1  synchronous load strobe for preset.
REQ-007 SHALL have port preset  input  4*DIGITS  load value, digit 0 in bits [3:0].
REQ-008 SHALL have port habilita  input  1  count enable; one decrement per enabled clock.
REQ-009 SHALL have port Q  output  4*DIGITS  current count, BCD per digit.
REQ-010 SHALL have port zero  output  1  high whenever Q equals all zeros.
REQ-011 SHALL have port fim  output  1  one-cycle pulse when a count reaches zero.
REQ-012 SHALL have port estado  output  2  state code: PARADO=00, CONTANDO=01, FIM=10.

Function
REQ-013 SHALL apply input priority reset > botao > habilita.
REQ-014 SHALL, on botao, load preset with each digit clamped to its maximum (LOW_MAX or TOP_MAX), and store the clamped value in an internal reload register.
REQ-015 SHALL, on botao, enter CONTANDO if the clamped value is nonzero, else enter FIM without pulsing fim.
REQ-016 SHALL, in CONTANDO with habilita=1, decrement the whole count by one in BCD; digit i decrements only when all lower digits are zero, and a borrowing zero digit wraps to its maximum.
REQ-017 SHALL, in CONTANDO with habilita=0, hold Q and state.
REQ-018 SHALL, on the enabled edge where Q becomes zero, assert fim for exactly that following cycle (registered, aligned with Q=0).
REQ-019 SHALL, in PARADO or FIM, ignore habilita and hold Q.
REQ-020 SHALL drive zero combinationally from Q; fim and estado SHALL be registered.
REQ-021 SHALL never present a digit above its maximum on Q.

Reset
REQ-022 SHALL, while reset=1, force Q=0, reload register=0, estado=PARADO, fim=0, regardless of clock.
REQ-023 SHALL, on reset asserted mid-count, abandon the count immediately; no fim pulse is generated.
REQ-024 SHALL resume normal operation on the first rising clock edge after reset deasserts.

Configuration
REQ-025 SHALL support macro CONTADOR_CASCATA_AUTO_RECARGA_EN.
REQ-026 SHALL, without the macro, enter FIM when Q reaches zero and hold Q=0 until botao or reset.
REQ-027 SHALL, with the macro, stay in CONTANDO when Q reaches zero (fim still pulses), then load the reload register on the next enabled clock; FIM is reachable only via a zero load.

Verification (DIGITS=2, LOW_MAX=9, TOP_MAX=5)
REQ-028 SHALL cover: botao with preset=0x12, habilita=1 -> Q = 0x12, 0x11, 0x10, 0x09, ..., 0x00; fim high one cycle with Q=0x00; estado=FIM; Q held.
REQ-029 SHALL cover: botao with preset=0x7A -> Q=0x59 (both digits clamped); estado=CONTANDO.
REQ-030 SHALL cover: botao and habilita high in the same cycle with Q=0x30 and preset=0x45 -> Q=0x45, no decrement.
REQ-031 SHALL cover: reset pulsed asynchronously between edges at Q=0x27 -> Q=0x00, estado=PARADO, fim=0 before the next edge.
REQ-032 SHALL cover: habilita toggled 1,0,0,1 from Q=0x05 -> Q = 0x04, 0x04, 0x04, 0x03.
REQ-033 SHALL cover, with macro: preset=0x02, habilita=1 -> Q = 0x02, 0x01, 0x00 (fim pulse), 0x02, 0x01; estado stays CONTANDO.
